// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache with one outstanding request.
// Load hit answers the next cycle; misses refill the whole line in word order before answering.
module dcache_dm #(
   parameter int INDEX_BITS = 6,
   parameter int WORD_BITS  = 2,
   parameter int ADDR_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   input  logic [2:0]        req_funct3_i,
   input  logic              flush_i,
   output logic              ready_o,
   output logic              resp_valid_o,
   output logic [31:0]       rdata_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wstrb_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
);
   localparam int TAG_W = ADDR_W - INDEX_BITS - WORD_BITS - 2;
   localparam int LINES = 1 << INDEX_BITS;
   localparam int DEPTH = 1 << (INDEX_BITS + WORD_BITS);

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_t;

   state_t                 state_q, state_d;
   logic [WORD_BITS-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:2]      addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [LINES-1:0]       valid_q, valid_d;
   logic [TAG_W-1:0]       tag_q [LINES];
   logic [31:0]            data_q [DEPTH];

   logic [INDEX_BITS-1:0]  req_idx, q_idx;
   logic [WORD_BITS-1:0]   req_word, q_word;
   logic [TAG_W-1:0]       req_tag, q_tag;
   logic                   req_hit, store_bad, store_upd, refill_we;
   logic [3:0]             strb_base, wstrb_sh;
   logic [31:0]            wdata_sh;

   assign req_idx  = req_addr_i[WORD_BITS+2 +: INDEX_BITS];
   assign req_word = req_addr_i[2 +: WORD_BITS];
   assign req_tag  = req_addr_i[ADDR_W-1 -: TAG_W];
   assign q_idx    = addr_q[WORD_BITS+2 +: INDEX_BITS];
   assign q_word   = addr_q[2 +: WORD_BITS];
   assign q_tag    = addr_q[ADDR_W-1 -: TAG_W];
   assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign wdata_sh = req_wdata_i << {req_addr_i[1:0], 3'b000};
   assign wstrb_sh = strb_base << req_addr_i[1:0];

   always_comb begin
      strb_base = 4'b0000;
      store_bad = 1'b1;
      case (req_funct3_i)
         3'b000: begin strb_base = 4'b0001; store_bad = 1'b0; end
         3'b001: begin strb_base = 4'b0011; store_bad = req_addr_i[0]; end
         3'b010: begin strb_base = 4'b1111; store_bad = |req_addr_i[1:0]; end
         default: ;
      endcase
   end

   assign ready_o      = (state_q == S_IDLE) && !flush_i;
   assign resp_valid_o = (state_q == S_RESP);
   assign rdata_o      = resp_valid_o ? rdata_q : 32'h0;
   assign err_o        = err_q;
   assign mem_req_o    = (state_q == S_REFILL) || (state_q == S_WRITE);
   assign mem_we_o     = (state_q == S_WRITE);
   assign mem_wdata_o  = wdata_q;
   assign mem_wstrb_o  = mem_we_o ? wstrb_q : 4'b0000;
   assign mem_addr_o   = (state_q == S_REFILL)
                         ? {addr_q[ADDR_W-1:WORD_BITS+2], cnt_q, 2'b00}
                         : {addr_q, 2'b00};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = 1'b0;
      valid_d   = valid_q;
      store_upd = 1'b0;
      refill_we = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush_i) begin
               valid_d = '0;
            end else if (req_valid_i) begin
               addr_d = req_addr_i[ADDR_W-1:2];
               if (req_we_i) begin
                  rdata_d = 32'h0;
                  if (store_bad) begin
                     err_d = 1'b1;
                  end else begin
                     wdata_d   = wdata_sh;
                     wstrb_d   = wstrb_sh;
                     store_upd = req_hit;
                     state_d   = S_WRITE;
                  end
               end else if (req_hit) begin
                  rdata_d = data_q[{req_idx, req_word}];
                  state_d = S_RESP;
               end else begin
                  // line is being overwritten word by word, so it must not hit meanwhile
                  valid_d[req_idx] = 1'b0;
                  cnt_d            = '0;
                  state_d          = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            if (mem_ack_i) begin
               refill_we = 1'b1;
               if (cnt_q == q_word) rdata_d = mem_rdata_i;
               if (cnt_q == '1) begin
                  valid_d[q_idx] = 1'b1;
                  cnt_d          = '0;
                  state_d        = S_RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_WRITE: if (mem_ack_i) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'b0000;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (store_upd) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_sh[b]) data_q[{req_idx, req_word}][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
      if (refill_we) begin
         data_q[{q_idx, cnt_q}] <= mem_rdata_i;
         tag_q[q_idx]           <= q_tag;
      end
   end
endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboarded bench for dcache_dm: responses and memory traffic are predicted at issue time.
module tb_dcache_dm;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic [2:0]  req_funct3_i = 3'b0;
   logic        flush_i = 1'b0;
   logic        ready_o, resp_valid_o, err_o, mem_req_o, mem_we_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'h0;

   dcache_dm dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
      .flush_i(flush_i), .ready_o(ready_o), .resp_valid_o(resp_valid_o), .rdata_o(rdata_o),
      .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i)
   );

   initial forever #5 clk_i = ~clk_i;

   typedef struct { bit is_err; bit chk; logic [31:0] data; int lat; int acc; } rsp_t;
   typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } mem_t;

   rsp_t        rsp_q[$];
   mem_t        mem_q[$];
   logic [31:0] mem_m [logic [31:0]];
   bit   [63:0] tb_valid = '0;
   logic [21:0] tb_tag [64];
   int          n_chk = 0, n_pass = 0, cyc = 0, n_mem = 0;
   int          acks_left = -1, wait_cnt = 0;
   bit          stray_ack = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return a ^ 32'h5EED_0000;
   endfunction

   // backing memory: acks on the falling edge so the DUT samples them on the next rising edge
   initial forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (stray_ack) begin
         mem_ack_i = 1'b1;
      end else if (!rst_i && mem_req_o && acks_left != 0) begin
         if (wait_cnt > 0) begin
            wait_cnt--;
         end else begin
            logic [31:0] mask, old;
            mem_t m;
            mem_ack_i = 1'b1;
            n_mem++;
            if (acks_left > 0) acks_left--;
            wait_cnt = $urandom_range(0, 2);
            if (mem_q.size() == 0) begin
               check("mem_unexpected", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
               m = mem_q.pop_front();
               check("mem_we", 32'(mem_we_o), 32'(m.we));
               check("mem_addr", mem_addr_o, m.addr);
               if (m.we) begin
                  for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m.wstrb[b]}};
                  check("mem_wstrb", 32'(mem_wstrb_o), 32'(m.wstrb));
                  check("mem_wdata", mem_wdata_o & mask, m.wdata & mask);
               end
            end
            if (mem_we_o) begin
               old = mem_rd(mem_addr_o);
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb_o[b]) old[8*b +: 8] = mem_wdata_o[8*b +: 8];
               mem_m[mem_addr_o] = old;
            end else begin
               mem_rdata_i = mem_rd(mem_addr_o);
            end
         end
      end
   end

   // response monitor
   initial forever begin
      @(negedge clk_i);
      if (!rst_i && (resp_valid_o || err_o)) begin
         if (rsp_q.size() == 0) begin
            check("rsp_unexpected", {30'b0, resp_valid_o, err_o}, 32'h0);
         end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            check("rsp_is_err", 32'(err_o), 32'(e.is_err));
            check("rsp_valid", 32'(resp_valid_o), 32'(!e.is_err));
            if (e.is_err) check("err_no_memreq", 32'(mem_req_o), 32'h0);
            if (e.chk) check("rdata", rdata_o, e.data);
            if (e.lat >= 0) check("hit_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3);
      rsp_t e;
      mem_t m;
      logic [5:0]  idx;
      logic [21:0] tag;
      logic [3:0]  base;
      bit          bad;
      int          n;
      idx = a[9:4];
      tag = a[31:10];
      e.is_err = 1'b0; e.chk = 1'b0; e.data = 32'h0; e.lat = -1; e.acc = 0;
      if (!we) begin
         e.chk  = 1'b1;
         e.data = mem_rd({a[31:2], 2'b00});
         if (tb_valid[idx] && tb_tag[idx] == tag) begin
            e.lat = 1;
         end else begin
            for (int w = 0; w < 4; w++) begin
               m.we = 1'b0; m.addr = {a[31:4], 4'h0} + 32'(4 * w); m.wdata = 0; m.wstrb = 0;
               mem_q.push_back(m);
            end
            tb_valid[idx] = 1'b1;
            tb_tag[idx]   = tag;
         end
      end else begin
         case (f3)
            3'd0: begin base = 4'b0001; bad = 1'b0; end
            3'd1: begin base = 4'b0011; bad = a[0]; end
            3'd2: begin base = 4'b1111; bad = (a[1:0] != 2'b00); end
            default: begin base = 4'b0000; bad = 1'b1; end
         endcase
         if (bad) begin
            e.is_err = 1'b1;
         end else begin
            m.we = 1'b1; m.addr = {a[31:2], 2'b00};
            m.wstrb = base << a[1:0];
            m.wdata = wd << (8 * a[1:0]);
            mem_q.push_back(m);
         end
      end
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = wd; req_funct3_i = f3;
      #1;
      n = 0;
      while (!ready_o && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!ready_o) check("ready_timeout", 32'(ready_o), 32'h1);
      e.acc = cyc;
      rsp_q.push_back(e);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      req_we_i = $urandom_range(0, 1);
      req_addr_i = $urandom;
      req_wdata_i = $urandom;
      req_funct3_i = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done();
      int n = 0;
      while ((rsp_q.size() != 0 || mem_q.size() != 0) && n < 300) begin
         @(posedge clk_i); n++;
      end
      check("txn_done", 32'(rsp_q.size() + mem_q.size()), 32'h0);
   endtask

   task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
      issue(we, a, wd, f3);
      wait_done();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(ready_o), 32'h1);
      check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'h0);
      check({tag, "_err"}, 32'(err_o), 32'h0);
      check({tag, "_rdata"}, rdata_o, 32'h0);
      check({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
      check({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
      check({tag, "_mem_wstrb"}, 32'(mem_wstrb_o), 32'h0);
   endtask

   initial begin
      int base_n;
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "global timeout");
   end

   initial begin
      int base_n;
      for (int w = 0; w < 4; w++) mem_m[32'h100 + 32'(4 * w)] = 32'hA0 + 32'(w);
      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // line fill, then hit on a neighbouring word with no memory traffic
      do_req(1'b0, 32'h100, 32'h0, 3'd0);
      base_n = n_mem;
      do_req(1'b0, 32'h104, 32'h0, 3'd0);
      check("hit_no_mem", 32'(n_mem), 32'(base_n));

      // byte and halfword stores on a hit line, then read back through the cache
      do_req(1'b1, 32'h101, 32'h55, 3'd0);
      do_req(1'b0, 32'h100, 32'h0, 3'd0);
      do_req(1'b1, 32'h106, 32'hBEEF, 3'd1);
      do_req(1'b0, 32'h104, 32'h0, 3'd0);

      // rejected stores: no memory access
      base_n = n_mem;
      do_req(1'b1, 32'h102, 32'h1234_5678, 3'd2);
      do_req(1'b1, 32'h101, 32'h1234, 3'd1);
      do_req(1'b1, 32'h100, 32'h1, 3'd3);
      check("err_no_mem", 32'(n_mem), 32'(base_n));

      // store miss does not allocate
      do_req(1'b1, 32'h300, 32'hCAFE_F00D, 3'd2);
      do_req(1'b0, 32'h300, 32'h0, 3'd0);

      // conflicting line evicts
      do_req(1'b0, 32'h100, 32'h0, 3'd0);
      do_req(1'b0, 32'h500, 32'h0, 3'd0);
      do_req(1'b0, 32'h100, 32'h0, 3'd0);

      // flush alone, then flush together with a request
      @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      check("flush_ready", 32'(ready_o), 32'h0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      tb_valid = '0;
      do_req(1'b0, 32'h100, 32'h0, 3'd0);
      @(negedge clk_i);
      base_n = n_mem;
      flush_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h104;
      #1;
      check("flush_req_ready", 32'(ready_o), 32'h0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0; req_valid_i = 1'b0;
      tb_valid = '0;
      repeat (5) @(posedge clk_i);
      check("flush_req_no_mem", 32'(n_mem), 32'(base_n));
      do_req(1'b0, 32'h104, 32'h0, 3'd0);

      // reset in the middle of a refill, after two acks
      acks_left = 2;
      base_n = n_mem;
      issue(1'b0, 32'h708, 32'h0, 3'd0);
      for (int i = 0; i < 100 && n_mem < base_n + 2; i++) @(posedge clk_i);
      repeat (2) @(posedge clk_i);
      check("refill_stalled", 32'(mem_req_o), 32'h1);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_reset_outputs("midrst");
      rsp_q.delete();
      mem_q.delete();
      tb_valid = '0;
      acks_left = -1;
      @(negedge clk_i);
      rst_i = 1'b0;
      stray_ack = 1'b1;
      @(negedge clk_i);
      stray_ack = 1'b0;
      repeat (3) @(posedge clk_i);
      do_req(1'b0, 32'h708, 32'h0, 3'd0);

      // random mix within two aliasing address windows
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 32'h7FF));
         if ($urandom_range(0, 2) == 0)
            do_req(1'b1, a, $urandom, 3'($urandom_range(0, 3)));
         else
            do_req(1'b0, a, 32'h0, 3'd0);
      end

      repeat (3) @(posedge clk_i);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
